commit_store_buffer: RTL and testbench

- FIFO of committed stores sitting directly upstream of the data memory store port.
- Accepts committed stores (byte/half/word) from the LSU commit path and converts each into a 64-bit-aligned write with byte strobes.
- Drains entries strictly in order, one outstanding store at a time, and retires an entry only on the memory's store-completion response.
- Provides a combinational load-hazard check so the LSU can stall loads that overlap buffered or in-flight stores.

---
 rtl/commit_store_buffer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_commit_store_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_store_buffer.sv
// commit_store_buffer
//   In-order FIFO of committed stores placed in front of the data memory
//   store port. Each byte/half/word store is turned into a dword-aligned
//   64-bit write with byte strobes. Entries drain one at a time and an
//   entry is retired only when the memory returns a store completion.
//   A combinational overlap check lets the LSU hold back loads that touch
//   bytes still owned by a buffered or in-flight store.
//
// Optional build macro:
//   STB_COALESCE_EN - merge an aligned store into the tail entry when both
//                     target the same dword and the tail has not been issued.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       committed store handshake
//   in_addr/in_data/in_size store byte address, right-justified data, size
//   misalign_err            one-cycle pulse: last accepted store was dropped
//   st_valid/st_ready       store request handshake to memory
//   st_addr/st_wdata/st_wstrb  head entry payload (dword address)
//   st_resp_valid/st_resp_ready  store completion handshake
//   ld_chk_addr/ld_chk_size load to check, ld_chk_hit = overlap found
//   sb_count/sb_empty       live entry count (in-flight included), empty flag
module commit_store_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     misalign_err,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic [ADDR_W-1:0]        st_addr,
  output logic [63:0]              st_wdata,
  output logic [7:0]               st_wstrb,
  input  logic                     st_resp_valid,
  output logic                     st_resp_ready,
  input  logic [ADDR_W-1:0]        ld_chk_addr,
  input  logic [1:0]               ld_chk_size,
  output logic                     ld_chk_hit,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_ISSUE = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  // Byte strobes for an access of the given size at the given dword offset.
  // Reserved size yields no strobes (never hits, never written).
  function automatic logic [7:0] strb_of(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Natural alignment test; reserved size is never aligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (lo[0] == 1'b0);
      2'd2:    ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate the word into both halves and shift it onto its byte lanes.
  function automatic logic [63:0] lanes_of(input logic [31:0] d, input logic [2:0] off);
    return {d, d} << {off, 3'b000};
  endfunction

  // Entry storage
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [63:0]       data_q [DEPTH];
  logic [7:0]        strb_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] in_dw_s;
  logic [7:0]        in_strb_s;
  logic [63:0]       in_lanes_s;
  logic              in_ok_s;
  logic              accept_s;
  logic              push_s;
  logic              merge_s;
  logic              pop_s;
  logic              hs_s;
  logic              st_valid_s;
  logic              resp_rdy_s;
  logic [ADDR_W-1:0] ld_dw_s;
  logic [7:0]        ld_strb_s;
  logic [PTR_W-1:0]  hz_rel_s;
  logic              hit_s;

  assign in_dw_s    = {in_addr[ADDR_W-1:3], 3'b000};
  assign in_strb_s  = strb_of(in_size, in_addr[2:0]);
  assign in_lanes_s = lanes_of(in_data, in_addr[2:0]);
  assign in_ok_s    = is_aligned(in_size, in_addr[1:0]);
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign accept_s   = in_valid && in_ready;

`ifdef STB_COALESCE_EN
  logic [PTR_W-1:0] tail_last_s;
  logic             tail_open_s;
  logic [63:0]      merged_data_s;

  assign tail_last_s = tail_q - PTR_W'(1);

  // Tail is still mergeable if it is behind the head, or it is the head
  // and is not being handed to memory this very cycle.
  always_comb begin
    tail_open_s = 1'b0;
    if (count_q > CNT_W'(1)) begin
      tail_open_s = 1'b1;
    end else begin
      tail_open_s = (state_q == S_ISSUE) && !hs_s;
    end
  end

  // Merge condition: aligned store into the same dword as a live, open tail.
  always_comb begin
    merge_s = 1'b0;
    if (accept_s && in_ok_s && (count_q != {CNT_W{1'b0}}) &&
        (addr_q[tail_last_s] == in_dw_s) && tail_open_s) begin
      merge_s = 1'b1;
    end else begin
      merge_s = 1'b0;
    end
  end

  // Overlay the incoming strobed bytes onto the tail entry data.
  always_comb begin
    merged_data_s = data_q[tail_last_s];
    for (int b = 0; b < 8; b++) begin
      if (in_strb_s[b]) begin
        merged_data_s[8*b +: 8] = in_lanes_s[8*b +: 8];
      end else begin
        merged_data_s[8*b +: 8] = data_q[tail_last_s][8*b +: 8];
      end
    end
  end
`else
  assign merge_s = 1'b0;
`endif

  assign push_s     = accept_s && in_ok_s && !merge_s;
  assign misalign_d = accept_s && !in_ok_s;

  // Drain FSM: issue head, then wait for its completion before popping.
  always_comb begin
    state_d    = state_q;
    st_valid_s = 1'b0;
    resp_rdy_s = 1'b0;
    hs_s       = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      S_ISSUE: begin
        st_valid_s = (count_q != {CNT_W{1'b0}});
        hs_s       = st_valid_s && st_ready;
        if (hs_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        resp_rdy_s = 1'b1;
        if (st_resp_valid) begin
          pop_s   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      state_q    <= S_ISSUE;
      misalign_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry payload write; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[tail_q] <= in_dw_s;
      data_q[tail_q] <= in_lanes_s;
      strb_q[tail_q] <= in_strb_s;
    end
`ifdef STB_COALESCE_EN
    else if (merge_s) begin
      data_q[tail_last_s] <= merged_data_s;
      strb_q[tail_last_s] <= strb_q[tail_last_s] | in_strb_s;
    end
`endif
  end

  assign ld_dw_s   = {ld_chk_addr[ADDR_W-1:3], 3'b000};
  assign ld_strb_s = strb_of(ld_chk_size, ld_chk_addr[2:0]);

  // Load hazard scan: an entry is live when its distance from head < count.
  always_comb begin
    hit_s    = 1'b0;
    hz_rel_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hz_rel_s = PTR_W'(i) - head_q;
      if (({1'b0, hz_rel_s} < count_q) && (addr_q[i] == ld_dw_s) &&
          ((strb_q[i] & ld_strb_s) != 8'h00)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign st_valid      = st_valid_s;
  assign st_addr       = addr_q[head_q];
  assign st_wdata      = data_q[head_q];
  assign st_wstrb      = strb_q[head_q];
  assign st_resp_ready = resp_rdy_s;
  assign ld_chk_hit    = hit_s;
  assign misalign_err  = misalign_q;
  assign sb_count      = count_q;
  assign sb_empty      = (count_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_commit_store_buffer.sv
module tb_commit_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        misalign_err;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [63:0] st_wdata;
  logic [7:0]  st_wstrb;
  logic        st_resp_valid;
  logic        st_resp_ready;
  logic [31:0] ld_chk_addr;
  logic [1:0]  ld_chk_size;
  logic        ld_chk_hit;
  logic [3:0]  sb_count;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;

  commit_store_buffer #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_size(in_size), .misalign_err(misalign_err),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_wstrb(st_wstrb),
    .st_resp_valid(st_resp_valid), .st_resp_ready(st_resp_ready),
    .ld_chk_addr(ld_chk_addr), .ld_chk_size(ld_chk_size), .ld_chk_hit(ld_chk_hit),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        exp_mis;
    logic [31:0] exp_staddr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, handshake, then complete it.
  task automatic drain_one(input logic [31:0] exp_a, input int lane, input logic [7:0] exp_b);
    int n;
    logic [7:0] exp_s;
    logic [63:0] sh;
    n = 0;
    exp_s = 8'h01 << lane;
    @(negedge clk);
    while (!st_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_valid", {63'd0, st_valid}, 64'd1);
    chk("drain_addr", {32'd0, st_addr}, {32'd0, exp_a});
    chk("drain_strb", {56'd0, st_wstrb}, {56'd0, exp_s});
    sh = st_wdata >> (8 * lane);
    chk("drain_byte", {56'd0, sh[7:0]}, {56'd0, exp_b});
    st_ready = 1'b1;
    @(posedge clk); #1;
    st_ready = 1'b0;
    st_resp_valid = 1'b1;
    @(posedge clk); #1;
    st_resp_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] mask;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_data = 32'd0; in_size = 2'd0;
    st_ready = 1'b0; st_resp_valid = 1'b0; ld_chk_addr = 32'd0; ld_chk_size = 2'd0;

    vecs[0] = '{32'h104, 32'hAABBCCDD, 2'd2, 32'h104, 2'd2, 1'b0, 32'h100, 8'hF0, 64'hAABBCCDD_00000000, 1'b1};
    vecs[1] = '{32'h203, 32'h0000005A, 2'd0, 32'h202, 2'd1, 1'b0, 32'h200, 8'h08, 64'h00000000_5A000000, 1'b1};
    vecs[2] = '{32'h206, 32'h00001234, 2'd1, 32'h204, 2'd1, 1'b0, 32'h200, 8'hC0, 64'h12340000_00000000, 1'b0};
    vecs[3] = '{32'h301, 32'h0000BEEF, 2'd1, 32'h300, 2'd0, 1'b1, 32'h000, 8'h00, 64'h0, 1'b0};
    vecs[4] = '{32'h400, 32'h12345678, 2'd3, 32'h400, 2'd2, 1'b1, 32'h000, 8'h00, 64'h0, 1'b0};
    vecs[5] = '{32'h408, 32'hDEADBEEF, 2'd2, 32'h40C, 2'd2, 1'b0, 32'h408, 8'h0F, 64'h00000000_DEADBEEF, 1'b0};
    vecs[6] = '{32'h507, 32'hFFFFFF77, 2'd0, 32'h507, 2'd0, 1'b0, 32'h500, 8'h80, 64'h77000000_00000000, 1'b1};
    vecs[7] = '{32'h600, 32'h01020304, 2'd2, 32'h700, 2'd2, 1'b0, 32'h600, 8'h0F, 64'h00000000_01020304, 1'b0};
    vecs[8] = '{32'h60A, 32'h0000CAFE, 2'd1, 32'h609, 2'd0, 1'b0, 32'h608, 8'h0C, 64'h00000000_CAFE0000, 1'b0};

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", {60'd0, sb_count}, 64'd0);
    chk("rst_empty", {63'd0, sb_empty}, 64'd1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_st_valid", {63'd0, st_valid}, 64'd0);
    chk("rst_resp_ready", {63'd0, st_resp_ready}, 64'd0);
    chk("rst_hit", {63'd0, ld_chk_hit}, 64'd0);
    chk("rst_misalign", {63'd0, misalign_err}, 64'd0);

    // Single-store placement, alignment and hazard table.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      st_ready = 1'b0;
      push(vecs[v].addr, vecs[v].data, vecs[v].size);
      ld_chk_addr = vecs[v].ld_addr;
      ld_chk_size = vecs[v].ld_size;
      @(negedge clk);
      chk("vec_misalign", {63'd0, misalign_err}, {63'd0, vecs[v].exp_mis});
      chk("vec_count", {60'd0, sb_count}, vecs[v].exp_mis ? 64'd0 : 64'd1);
      chk("vec_st_valid", {63'd0, st_valid}, {63'd0, !vecs[v].exp_mis});
      chk("vec_hit", {63'd0, ld_chk_hit}, {63'd0, vecs[v].exp_hit});
      if (!vecs[v].exp_mis) begin
        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{vecs[v].exp_strb[b]}};
        chk("vec_addr", {32'd0, st_addr}, {32'd0, vecs[v].exp_staddr});
        chk("vec_strb", {56'd0, st_wstrb}, {56'd0, vecs[v].exp_strb});
        chk("vec_data", st_wdata & mask, vecs[v].exp_data);
      end
      @(negedge clk);
      chk("vec_mis_clear", {63'd0, misalign_err}, 64'd0);
    end

    // Issue, wait, complete: sb_empty returns one cycle after completion.
    do_reset();
    st_ready = 1'b1;
    push(32'h104, 32'hAABBCCDD, 2'd2);
    @(negedge clk);
    chk("a_st_valid", {63'd0, st_valid}, 64'd1);
    chk("a_addr", {32'd0, st_addr}, 64'h100);
    chk("a_strb", {56'd0, st_wstrb}, 64'hF0);
    chk("a_data_hi", {32'd0, st_wdata[63:32]}, 64'hAABBCCDD);
    @(posedge clk); #1;
    st_ready = 1'b0;
    @(negedge clk);
    chk("a_wait_valid", {63'd0, st_valid}, 64'd0);
    chk("a_wait_rr", {63'd0, st_resp_ready}, 64'd1);
    @(posedge clk); #1;
    st_resp_valid = 1'b1;
    @(negedge clk);
    chk("a_not_empty", {63'd0, sb_empty}, 64'd0);
    @(posedge clk); #1;
    st_resp_valid = 1'b0;
    @(negedge clk);
    chk("a_empty", {63'd0, sb_empty}, 64'd1);
    chk("a_rr_low", {63'd0, st_resp_ready}, 64'd0);

    // Fill to DEPTH, drain partially, refill across the wrap, drain all.
    do_reset();
    st_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h200 + i, 32'hA0 + i, 2'd0);
    @(negedge clk);
    chk("b_full_count", {60'd0, sb_count}, 64'd8);
    chk("b_full_ready", {63'd0, in_ready}, 64'd0);
    push(32'h300, 32'h55, 2'd0);
    @(negedge clk);
    chk("b_full_hold", {60'd0, sb_count}, 64'd8);
    for (int i = 0; i < 3; i++) drain_one(32'h200, i, 8'hA0 + 8'(i));
    for (int j = 0; j < 3; j++) push(32'h208 + j, 32'hB0 + j, 2'd0);
    @(negedge clk);
    chk("b_refill_count", {60'd0, sb_count}, 64'd8);
    chk("b_refill_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 3; i < 8; i++) drain_one(32'h200, i, 8'hA0 + 8'(i));
    for (int j = 0; j < 3; j++) drain_one(32'h208, j, 8'hB0 + 8'(j));
    @(negedge clk);
    chk("b_drained", {63'd0, sb_empty}, 64'd1);

    // Hazard against the in-flight entry.
    do_reset();
    st_ready = 1'b0;
    push(32'h400, 32'h11223344, 2'd2);
    st_ready = 1'b1;
    @(posedge clk); #1;
    st_ready = 1'b0;
    ld_chk_addr = 32'h402; ld_chk_size = 2'd1;
    @(negedge clk);
    chk("d_wait_rr", {63'd0, st_resp_ready}, 64'd1);
    chk("d_hit_402", {63'd0, ld_chk_hit}, 64'd1);
    ld_chk_addr = 32'h404;
    @(negedge clk);
    chk("d_hit_404", {63'd0, ld_chk_hit}, 64'd0);
    ld_chk_addr = 32'h402;
    st_resp_valid = 1'b1;
    @(posedge clk); #1;
    st_resp_valid = 1'b0;
    @(negedge clk);
    chk("d_hit_after", {63'd0, ld_chk_hit}, 64'd0);

    // Reset while waiting on a completion with three live entries.
    do_reset();
    st_ready = 1'b0;
    push(32'h800, 32'h1, 2'd2);
    push(32'h808, 32'h2, 2'd2);
    push(32'h810, 32'h3, 2'd2);
    st_ready = 1'b1;
    @(posedge clk); #1;
    st_ready = 1'b0;
    @(negedge clk);
    chk("e_count3", {60'd0, sb_count}, 64'd3);
    chk("e_in_wait", {63'd0, st_resp_ready}, 64'd1);
    do_reset();
    @(negedge clk);
    chk("e_rst_count", {60'd0, sb_count}, 64'd0);
    chk("e_rst_valid", {63'd0, st_valid}, 64'd0);
    chk("e_rst_rr", {63'd0, st_resp_ready}, 64'd0);
    st_resp_valid = 1'b1;
    @(posedge clk); #1;
    st_resp_valid = 1'b0;
    @(negedge clk);
    chk("e_late_resp", {60'd0, sb_count}, 64'd0);
    push(32'h900, 32'h9, 2'd2);
    @(negedge clk);
    chk("e_reissue", {63'd0, st_valid}, 64'd1);
    chk("e_reissue_cnt", {60'd0, sb_count}, 64'd1);

    // Same-dword byte stores into an unissued tail, then into an issued one.
    do_reset();
    st_ready = 1'b0;
    push(32'h500, 32'h11, 2'd0);
    push(32'h501, 32'h22, 2'd0);
    @(negedge clk);
`ifdef STB_COALESCE_EN
    chk("f_count", {60'd0, sb_count}, 64'd1);
    chk("f_strb", {56'd0, st_wstrb}, 64'h03);
    chk("f_data", {48'd0, st_wdata[15:0]}, 64'h2211);
`else
    chk("f_count", {60'd0, sb_count}, 64'd2);
    chk("f_strb", {56'd0, st_wstrb}, 64'h01);
    chk("f_data", {56'd0, st_wdata[7:0]}, 64'h11);
`endif
    st_ready = 1'b1;
    @(posedge clk); #1;
    st_ready = 1'b0;
    push(32'h502, 32'h33, 2'd0);
    @(negedge clk);
`ifdef STB_COALESCE_EN
    chk("f_issued_nomerge", {60'd0, sb_count}, 64'd2);
`else
    chk("f_issued_nomerge", {60'd0, sb_count}, 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
